// File: rtl/tpu_pkg.sv
// Shared defaults and FSM encoding for the systolic-array operand feeder.
package tpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feed_state_e;

endpackage

// File: rtl/skew_fifo.sv
// Circular FIFO holding aligned operand vectors {last, lane1, lane0}.
// Writes and pointer updates are clocked; read data is the head entry.
module skew_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Internal guards make overflow and underflow impossible regardless of caller.
    assign do_push = push && (count_q < FULL) && !clear;
    assign do_pop  = pop && (count_q != '0) && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/operand_skew_feeder.sv
// Buffers aligned two-row operand vectors and injects them into the array
// with row 1 lagging row 0 by one advancing cycle.
//
//   state  | meaning
//   IDLE   | no batch in flight; next pop starts one
//   STREAM | batch in progress, popping whenever data and no stall
//   DRAIN  | last row-0 element issued; waiting one step for row-1 tail
module operand_skew_feeder
    import tpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_lane0,
    input  logic [DATA_W-1:0] in_lane1,
    output logic              skew_valid0,
    output logic [DATA_W-1:0] skew_lane0,
    output logic              skew_valid1,
    output logic [DATA_W-1:0] skew_lane1,
    output logic              done
);

    localparam int EW = 2*DATA_W + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]     rd_entry;
    logic [CW-1:0]     count;
    logic              push, pop;
    logic              rd_last;
    logic [DATA_W-1:0] rd_lane0, rd_lane1;

    feed_state_e       state_q, state_d;
    logic              valid0_q, valid0_d;
    logic [DATA_W-1:0] lane0_q, lane0_d;
    logic              dly_valid_q, dly_valid_d;
    logic [DATA_W-1:0] dly_lane1_q, dly_lane1_d;
    logic              dly_last_q, dly_last_d;
    logic              valid1_q, valid1_d;
    logic [DATA_W-1:0] lane1_q, lane1_d;
    logic              done_q, done_d;

    assign in_ready = (count < FULL);
    assign push     = in_valid && in_ready && !clear;
    assign pop      = (count != '0) && !stall && !clear && (state_q != DRAIN);
    assign {rd_last, rd_lane1, rd_lane0} = rd_entry;

    skew_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .wdata ({in_last, in_lane1, in_lane0}),
        .pop   (pop),
        .rdata (rd_entry),
        .count (count)
    );

    // Stall freezes everything except done, which stays a single-cycle event.
    always_comb begin
        state_d     = state_q;
        valid0_d    = valid0_q;
        lane0_d     = lane0_q;
        dly_valid_d = dly_valid_q;
        dly_lane1_d = dly_lane1_q;
        dly_last_d  = dly_last_q;
        valid1_d    = valid1_q;
        lane1_d     = lane1_q;
        done_d      = 1'b0;
        if (clear) begin
            state_d     = IDLE;
            valid0_d    = 1'b0;
            lane0_d     = '0;
            dly_valid_d = 1'b0;
            dly_lane1_d = '0;
            dly_last_d  = 1'b0;
            valid1_d    = 1'b0;
            lane1_d     = '0;
        end else if (!stall) begin
            valid0_d    = pop;
            lane0_d     = pop ? rd_lane0 : '0;
            dly_valid_d = pop;
            dly_lane1_d = pop ? rd_lane1 : '0;
            dly_last_d  = pop && rd_last;
            valid1_d    = dly_valid_q;
            lane1_d     = dly_lane1_q;
            done_d      = dly_valid_q && dly_last_q;
            case (state_q)
                IDLE, STREAM: if (pop) state_d = rd_last ? DRAIN : STREAM;
                DRAIN:        state_d = IDLE;
                default:      state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            valid0_q    <= 1'b0;
            lane0_q     <= '0;
            dly_valid_q <= 1'b0;
            dly_lane1_q <= '0;
            dly_last_q  <= 1'b0;
            valid1_q    <= 1'b0;
            lane1_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid0_q    <= valid0_d;
            lane0_q     <= lane0_d;
            dly_valid_q <= dly_valid_d;
            dly_lane1_q <= dly_lane1_d;
            dly_last_q  <= dly_last_d;
            valid1_q    <= valid1_d;
            lane1_q     <= lane1_d;
            done_q      <= done_d;
        end
    end

    assign skew_valid0 = valid0_q;
    assign skew_lane0  = lane0_q;
    assign skew_valid1 = valid1_q;
    assign skew_lane1  = lane1_q;
    assign done        = done_q;

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Scoreboard bench for operand_skew_feeder: accepted vectors are queued,
// a monitor predicts each step from the feeder's rules and compares.
module tb_operand_skew_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset, clear, stall, in_valid, in_last, in_ready;
    logic [DW-1:0] in_lane0, in_lane1, skew_lane0, skew_lane1;
    logic          skew_valid0, skew_valid1, done;

    always #5 clk = ~clk;

    operand_skew_feeder #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .stall       (stall),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .in_lane0    (in_lane0),
        .in_lane1    (in_lane1),
        .skew_valid0 (skew_valid0),
        .skew_lane0  (skew_lane0),
        .skew_valid1 (skew_valid1),
        .skew_lane1  (skew_lane1),
        .done        (done)
    );

    typedef struct packed {
        logic [DW-1:0] l0;
        logic [DW-1:0] l1;
        logic          last;
    } vec_t;

    vec_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    bit            adv_e = 0, clr_e = 0, rst_e = 0;
    int            pre_size = 0;
    bit            stage_v = 0, drain_m = 0;
    vec_t          stage;
    logic          h_v0 = 0, h_v1 = 0;
    logic [DW-1:0] h_l0 = '0, h_l1 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Record what happened at each edge; handshake uses the model's occupancy.
    always @(posedge clk) begin
        pre_size = exp_q.size();
        rst_e    = reset;
        clr_e    = clear;
        adv_e    = !stall && !clear && !reset;
        if (reset || clear) exp_q.delete();
        else if (in_valid && pre_size < DEPTH)
            exp_q.push_back('{l0: in_lane0, l1: in_lane1, last: in_last});
    end

    always @(negedge clk) begin : monitor
        vec_t e;
        if (reset || rst_e || clr_e) begin
            exp_q.delete();
            stage_v = 0;
            drain_m = 0;
            chk("flush_v0", skew_valid0, 0);
            chk("flush_l0", skew_lane0, 0);
            chk("flush_v1", skew_valid1, 0);
            chk("flush_l1", skew_lane1, 0);
            chk("flush_done", done, 0);
        end else if (!adv_e) begin
            chk("hold_v0", skew_valid0, h_v0);
            chk("hold_l0", skew_lane0, h_l0);
            chk("hold_v1", skew_valid1, h_v1);
            chk("hold_l1", skew_lane1, h_l1);
            chk("hold_done", done, 0);
        end else begin
            chk("valid1", skew_valid1, stage_v);
            chk("lane1", skew_lane1, stage_v ? stage.l1 : '0);
            chk("done", done, stage_v && stage.last);
            if (drain_m || pre_size == 0) begin
                chk("valid0_bubble", skew_valid0, 0);
                chk("lane0_bubble", skew_lane0, 0);
                stage_v = 0;
                drain_m = 0;
            end else begin
                e = exp_q.pop_front();
                chk("valid0", skew_valid0, 1);
                chk("lane0", skew_lane0, e.l0);
                stage   = e;
                stage_v = 1;
                drain_m = e.last;
            end
        end
        if (done) done_cnt++;
        chk("in_ready", in_ready, exp_q.size() < DEPTH);
        h_v0 = skew_valid0; h_l0 = skew_lane0;
        h_v1 = skew_valid1; h_l1 = skew_lane1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic l);
        bit acc;
        int n;
        n = 0;
        in_valid = 1; in_lane0 = a; in_lane1 = b; in_last = l;
        do begin
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end
        in_valid = 0;
    endtask

    task automatic single_vec(input logic [DW-1:0] a, input logic [DW-1:0] b);
        send(a, b, 1'b1);
        step();
        chk("sv_n1_v0", skew_valid0, 1);
        chk("sv_n1_l0", skew_lane0, a);
        chk("sv_n1_v1", skew_valid1, 0);
        chk("sv_n1_done", done, 0);
        step();
        chk("sv_n2_v0", skew_valid0, 0);
        chk("sv_n2_v1", skew_valid1, 1);
        chk("sv_n2_l1", skew_lane1, b);
        chk("sv_n2_done", done, 1);
        step();
        chk("sv_n3_done", done, 0);
        chk("sv_n3_v1", skew_valid1, 0);
    endtask

    initial begin
        int d0;
        reset = 1; clear = 0; stall = 0; in_valid = 0; in_last = 0;
        in_lane0 = '0; in_lane1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 0;
        chk("ready_after_reset", in_ready, 1);

        single_vec(8'h11, 8'h22);

        d0 = done_cnt;
        send(8'hA0, 8'hA1, 0);
        send(8'hB0, 8'hB1, 0);
        send(8'hC0, 8'hC1, 0);
        send(8'hD0, 8'hD1, 1);
        repeat (6) step();
        chk("burst_one_done", done_cnt - d0, 1);

        stall = 1;
        for (int i = 0; i < 4; i++) send(8'(8'h40 + i), 8'(8'h50 + i), 0);
        chk("full_ready_low", in_ready, 0);
        in_valid = 1; in_lane0 = 8'h44; in_lane1 = 8'h54; in_last = 1;
        step();
        step();
        chk("full_ready_held", in_ready, 0);
        stall = 0;
        send(8'h44, 8'h54, 1);
        repeat (10) step();

        send(8'h61, 8'h71, 0);
        send(8'h62, 8'h72, 0);
        send(8'h63, 8'h73, 0);
        stall = 1;
        send(8'h64, 8'h74, 0);
        send(8'h65, 8'h75, 0);
        stall = 0;
        send(8'h66, 8'h76, 1);
        repeat (10) step();

        send(8'h81, 8'h91, 0);
        send(8'h82, 8'h92, 0);
        stall = 1;
        send(8'h83, 8'h93, 0);
        send(8'h84, 8'h94, 0);
        d0 = done_cnt;
        clear = 1;
        step();
        clear = 0;
        stall = 0;
        chk("clr_v0", skew_valid0, 0);
        chk("clr_v1", skew_valid1, 0);
        chk("clr_ready", in_ready, 1);
        repeat (3) step();
        chk("clr_no_done", done_cnt - d0, 0);

        d0 = done_cnt;
        send(8'h33, 8'h44, 1);
        step();
        #2 reset = 1;
        #1;
        chk("rst_async_v0", skew_valid0, 0);
        chk("rst_async_l0", skew_lane0, 0);
        chk("rst_async_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 0;
        chk("rst_no_done", done_cnt - d0, 0);
        single_vec(8'h11, 8'h22);

        for (int i = 0; i < 600; i++) begin
            stall    = ($urandom_range(0, 99) < 15);
            clear    = ($urandom_range(0, 99) < 2);
            in_valid = ($urandom_range(0, 99) < 55);
            in_lane0 = 8'($urandom);
            in_lane1 = 8'($urandom);
            in_last  = ($urandom_range(0, 4) == 0);
            step();
        end
        stall = 0; clear = 0; in_valid = 0; in_last = 0;
        repeat (20) step();
        chk("drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
